// File: rtl/heap_request_arbiter.sv
// Two-client round-robin requester for the heap alloc/free handshake.
// One heap transaction in flight; tracks live allocations and flags protocol misuse.
module heap_request_arbiter #(
    parameter int unsigned addrBits  = 8,
    parameter int unsigned countBits = addrBits + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0Alloc,
    input  logic                 req0Free,
    input  logic [addrBits-1:0]  req0FreeAddress,
    output logic                 done0,
    input  logic                 req1Alloc,
    input  logic                 req1Free,
    input  logic [addrBits-1:0]  req1FreeAddress,
    output logic                 done1,
    output logic [addrBits-1:0]  grantAddress,
    output logic                 heapAlloc,
    output logic                 heapFree,
    output logic [addrBits-1:0]  heapFreeAddress,
    input  logic                 heapFinished,
    input  logic [addrBits-1:0]  heapAllocAddress,
    output logic                 busy,
    output logic [countBits-1:0] liveCount,
    output logic                 protocolError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t               state_q;
    logic                 ptr_q;
    logic                 client_q;
    logic                 op_alloc_q;
    logic [addrBits-1:0]  free_addr_q;
    logic                 done0_q;
    logic                 done1_q;
    logic [addrBits-1:0]  grant_q;
    logic                 heap_alloc_q;
    logic                 heap_free_q;
    logic [addrBits-1:0]  heap_free_addr_q;
    logic                 busy_q;
    logic [countBits-1:0] live_q;
    logic                 perr_q;

    logic                 pend0_c;
    logic                 pend1_c;
    logic                 win_c;
    logic                 win_alloc_c;
    logic                 win_free_c;
    logic [addrBits-1:0]  win_addr_c;

    // Winner selection: pointer client breaks a tie, otherwise the lone pending client.
    always_comb begin
        pend0_c     = req0Alloc | req0Free;
        pend1_c     = req1Alloc | req1Free;
        win_c       = (pend0_c && pend1_c) ? ptr_q : pend1_c;
        win_alloc_c = win_c ? req1Alloc : req0Alloc;
        win_free_c  = win_c ? req1Free : req0Free;
        win_addr_c  = win_c ? req1FreeAddress : req0FreeAddress;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ptr_q            <= 1'b0;
            client_q         <= 1'b0;
            op_alloc_q       <= 1'b0;
            free_addr_q      <= '0;
            done0_q          <= 1'b0;
            done1_q          <= 1'b0;
            grant_q          <= '0;
            heap_alloc_q     <= 1'b0;
            heap_free_q      <= 1'b0;
            heap_free_addr_q <= '0;
            busy_q           <= 1'b0;
            live_q           <= '0;
            perr_q           <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pend0_c || pend1_c) begin
                        client_q    <= win_c;
                        op_alloc_q  <= win_alloc_c;
                        free_addr_q <= win_addr_c;
                        ptr_q       <= ~win_c;
                        if (win_alloc_c && win_free_c) begin
                            perr_q <= 1'b1;
                        end
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    heap_alloc_q     <= op_alloc_q;
                    heap_free_q      <= ~op_alloc_q;
                    heap_free_addr_q <= free_addr_q;
                    state_q          <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion results are registered here so they are visible in DONE.
                    if (heapFinished) begin
                        heap_alloc_q <= 1'b0;
                        heap_free_q  <= 1'b0;
                        done0_q      <= ~client_q;
                        done1_q      <= client_q;
                        if (op_alloc_q) begin
                            grant_q <= heapAllocAddress;
                            if (live_q != '1) begin
                                live_q <= live_q + countBits'(1);
                            end
                        end else if (live_q == '0) begin
                            perr_q <= 1'b1;
                        end else begin
                            live_q <= live_q - countBits'(1);
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!heapFinished) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done0           = done0_q;
    assign done1           = done1_q;
    assign grantAddress    = grant_q;
    assign heapAlloc       = heap_alloc_q;
    assign heapFree        = heap_free_q;
    assign heapFreeAddress = heap_free_addr_q;
    assign busy            = busy_q;
    assign liveCount       = live_q;
    assign protocolError   = perr_q;

endmodule

// File: tb/tb_heap_request_arbiter.sv
// Directed bench for heap_request_arbiter with a small bump/free-list heap model.
module tb_heap_request_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0Alloc, req0Free, req1Alloc, req1Free;
    logic [7:0] req0FreeAddress, req1FreeAddress;
    logic       done0, done1;
    logic [7:0] grantAddress;
    logic       heapAlloc, heapFree;
    logic [7:0] heapFreeAddress;
    logic       heapFinished;
    logic [7:0] heapAllocAddress;
    logic       busy;
    logic [8:0] liveCount;
    logic       protocolError;

    int n_vec = 0;
    int n_err = 0;

    heap_request_arbiter #(.addrBits(8), .countBits(9)) dut (
        .clk(clk), .reset(reset),
        .req0Alloc(req0Alloc), .req0Free(req0Free), .req0FreeAddress(req0FreeAddress), .done0(done0),
        .req1Alloc(req1Alloc), .req1Free(req1Free), .req1FreeAddress(req1FreeAddress), .done1(done1),
        .grantAddress(grantAddress),
        .heapAlloc(heapAlloc), .heapFree(heapFree), .heapFreeAddress(heapFreeAddress),
        .heapFinished(heapFinished), .heapAllocAddress(heapAllocAddress),
        .busy(busy), .liveCount(liveCount), .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    // Heap model: bump pointer from 0, LIFO free list, two-cycle completion latency.
    logic [7:0] heap_end;
    logic [7:0] fl[$];
    int         lat_cnt;
    always @(posedge clk) begin
        if (reset) begin
            heapFinished     <= 1'b0;
            heapAllocAddress <= 8'h0;
            heap_end         <= 8'h0;
            lat_cnt          <= 0;
            fl.delete();
        end else if ((heapAlloc || heapFree) && !heapFinished) begin
            if (lat_cnt == 1) begin
                heapFinished <= 1'b1;
                lat_cnt      <= 0;
                if (heapAlloc) begin
                    if (fl.size() > 0) begin
                        heapAllocAddress <= fl[$];
                        void'(fl.pop_back());
                    end else begin
                        heapAllocAddress <= heap_end;
                        heap_end         <= heap_end + 8'd1;
                    end
                end else begin
                    fl.push_back(heapFreeAddress);
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else if (!(heapAlloc || heapFree)) begin
            heapFinished <= 1'b0;
        end
    end

    // Any new heap request raised while the heap still shows finished is a violation.
    logic req_prev = 1'b0;
    int   viol = 0;
    always @(posedge clk) begin
        req_prev <= heapAlloc | heapFree;
        if ((heapAlloc || heapFree) && !req_prev && heapFinished) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for client c's done pulse, check results, drop its request, confirm one-cycle pulse.
    task automatic serve(input int c, input logic [7:0] ea, input logic [8:0] el, input string tag);
        bit   seen = 1'b0;
        logic pf   = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            pf = heapFinished;
            tick();
            if ((c == 0) ? done0 : done1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_done_lat"}, 32'(pf), 1);
            chk({tag, "_grant"}, 32'(grantAddress), 32'(ea));
            chk({tag, "_live"}, 32'(liveCount), 32'(el));
            if (c == 0) begin
                req0Alloc = 1'b0; req0Free = 1'b0;
            end else begin
                req1Alloc = 1'b0; req1Free = 1'b0;
            end
            tick();
            chk({tag, "_done_pulse"}, 32'((c == 0) ? done0 : done1), 0);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            tick();
            if (!busy) idle = 1'b1;
        end
        chk({tag, "_idle"}, 32'(idle), 1);
    endtask

    initial begin
        reset = 1'b1;
        req0Alloc = 1'b0; req0Free = 1'b0; req0FreeAddress = 8'h0;
        req1Alloc = 1'b0; req1Free = 1'b0; req1FreeAddress = 8'h0;
        tick(); tick();
        chk("rst_alloc", 32'(heapAlloc), 0);
        chk("rst_free", 32'(heapFree), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_live", 32'(liveCount), 0);
        chk("rst_perr", 32'(protocolError), 0);
        chk("rst_grant", 32'(grantAddress), 0);
        reset = 1'b0;
        tick();

        // Single alloc, client 0: heapAlloc high two cycles after request.
        req0Alloc = 1'b1;
        tick();
        chk("t1_issue_alloc", 32'(heapAlloc), 0);
        chk("t1_issue_busy", 32'(busy), 1);
        tick();
        chk("t1_alloc_hi", 32'(heapAlloc), 1);
        serve(0, 8'd0, 9'd1, "t1");
        wait_idle("t1");

        // Contention round 1: pointer now at client 1 after client 0 was served.
        req0Alloc = 1'b1; req1Alloc = 1'b1;
        serve(1, 8'd1, 9'd2, "c1a");
        serve(0, 8'd2, 9'd3, "c1b");
        wait_idle("c1");

        // Contention round 2: client 0 won last, so client 1 wins again.
        req0Alloc = 1'b1; req1Alloc = 1'b1;
        serve(1, 8'd3, 9'd4, "c2a");
        serve(0, 8'd4, 9'd5, "c2b");
        wait_idle("c2");

        // Free of address 2 by client 1.
        req1Free = 1'b1; req1FreeAddress = 8'd2;
        tick(); tick();
        chk("fr_free_hi", 32'(heapFree), 1);
        chk("fr_alloc_lo", 32'(heapAlloc), 0);
        chk("fr_addr", 32'(heapFreeAddress), 2);
        serve(1, 8'd4, 9'd4, "fr");
        wait_idle("fr");
        chk("fr_fl_size", 32'(fl.size()), 1);
        if (fl.size() > 0) chk("fr_fl_head", 32'(fl[$]), 2);

        // Alloc+free together on client 0: alloc wins (reuses address 2), error flagged.
        req0Alloc = 1'b1; req0Free = 1'b1; req0FreeAddress = 8'd7;
        tick(); tick();
        chk("er_alloc_hi", 32'(heapAlloc), 1);
        chk("er_free_lo", 32'(heapFree), 0);
        serve(0, 8'd2, 9'd5, "er");
        chk("er_perr", 32'(protocolError), 1);
        wait_idle("er");

        // Reset while waiting on the heap.
        req0Alloc = 1'b1;
        tick(); tick();
        chk("rw_alloc_hi", 32'(heapAlloc), 1);
        reset = 1'b1; req0Alloc = 1'b0;
        tick();
        chk("rw_alloc", 32'(heapAlloc), 0);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_live", 32'(liveCount), 0);
        chk("rw_perr", 32'(protocolError), 0);
        chk("rw_grant", 32'(grantAddress), 0);
        reset = 1'b0;
        tick();

        // Pointer back at client 0: contention serves client 0 first, fresh heap.
        req0Alloc = 1'b1; req1Alloc = 1'b1;
        serve(0, 8'd0, 9'd1, "pa");
        serve(1, 8'd1, 9'd2, "pb");
        wait_idle("p");

        // Free with liveCount==0: still forwarded, count stays 0, error flagged.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req1Free = 1'b1; req1FreeAddress = 8'd9;
        tick(); tick();
        chk("z_free_hi", 32'(heapFree), 1);
        chk("z_addr", 32'(heapFreeAddress), 9);
        serve(1, 8'd0, 9'd0, "z");
        chk("z_perr", 32'(protocolError), 1);
        wait_idle("z");

        chk("no_b2b", 32'(viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
